// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned MDU_CNT_W = 4;
  localparam int unsigned REG_ZERO  = 0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one E-stage ALU operand; M beats W, x0 never forwarded.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardE
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (RsE != REG_W'(REG_ZERO)) begin
      if (RegWriteM && (RdM == RsE))      sel = FWD_M;
      else if (RegWriteW && (RdW == RsE)) sel = FWD_W;
    end
  end

  assign ForwardE = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: forwarding selects, load-use and MDU stalls, flushes.
// Optional stall/flush performance counters when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MDU_LAT = 4
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic             MduOpD,
  input  logic [REG_W-1:0] RdD,
  input  logic             RegWriteD,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic             LoadE,
  input  logic             MduStartE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MduBusy,
  output logic             MduDone,
  output logic [REG_W-1:0] MduRd
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] LwStallCnt,
  output logic [CNT_W-1:0] MduStallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int unsigned CNT_LOAD = MDU_LAT - 1;

  mdu_state_e             state, stateNext;
  logic [MDU_CNT_W-1:0]   cnt, cntNext;
  logic [REG_W-1:0]       mduRdNext;
  logic                   lwStall, mduStall, mduHit;

  fwd_sel_unit #(.REG_W(REG_W)) u_fwd_a (
    .RsE(Rs1E), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ForwardE(ForwardAE)
  );

  fwd_sel_unit #(.REG_W(REG_W)) u_fwd_b (
    .RsE(Rs2E), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ForwardE(ForwardBE)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      MduRd <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      MduRd <= mduRdNext;
    end
  end

  // MDU sequencing plus all stall/flush decode.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mduRdNext = MduRd;
    MduBusy   = 1'b0;
    MduDone   = 1'b0;
    case (state)
      IDLE: begin
        if (MduStartE) begin
          stateNext = BUSY;
          cntNext   = MDU_CNT_W'(CNT_LOAD);
          mduRdNext = RdE;
        end
      end
      BUSY: begin
        MduBusy = 1'b1;
        if (cnt == '0) begin
          MduDone   = 1'b1;
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    lwStall = LoadE && (RdE != REG_W'(REG_ZERO)) && ((RdE == Rs1D) || (RdE == Rs2D));
    mduHit  = (MduRd != REG_W'(REG_ZERO)) &&
              ((Rs1D == MduRd) || (Rs2D == MduRd) || (RegWriteD && (RdD == MduRd)));
    // The MduDone cycle writes back, so it no longer blocks D.
    mduStall = MduBusy && !MduDone && (MduOpD || mduHit);

    StallF = lwStall || mduStall;
    StallD = lwStall || mduStall;
    FlushE = lwStall || mduStall || PCSrcE;
    FlushD = PCSrcE;
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LwStallCnt  <= '0;
      MduStallCnt <= '0;
      FlushCnt    <= '0;
    end else begin
      if (lwStall && (LwStallCnt != '1))   LwStallCnt  <= LwStallCnt + CNT_W'(1);
      if (mduStall && (MduStallCnt != '1)) MduStallCnt <= MduStallCnt + CNT_W'(1);
      if (PCSrcE && (FlushCnt != '1))      FlushCnt    <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, MDU sequences, random vs. model.
module tb_hazard_ctrl;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned MDU_LAT = 4;
`ifdef HAZARD_PERF_EN
  localparam int unsigned CNT_W   = 4;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_W-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MduOpD, RegWriteD, LoadE, MduStartE, PCSrcE, RegWriteM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE, MduBusy, MduDone;
  logic [REG_W-1:0] MduRd;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] LwStallCnt, MduStallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W(REG_W), .MDU_LAT(MDU_LAT)
`ifdef HAZARD_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .MduOpD(MduOpD), .RdD(RdD), .RegWriteD(RegWriteD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE), .MduStartE(MduStartE),
    .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .MduBusy(MduBusy), .MduDone(MduDone), .MduRd(MduRd)
`ifdef HAZARD_PERF_EN
    , .LwStallCnt(LwStallCnt), .MduStallCnt(MduStallCnt), .FlushCnt(FlushCnt)
`endif
  );

  int nVec = 0;
  int nMis = 0;

  // Reference model state: MDU as "cycles left", counters as plain integers.
  bit             mBusy;
  int             mRem;
  logic [REG_W-1:0] mRd;
  longint         mLw, mMdu, mFl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [REG_W-1:0] rs);
    if (rs == 0) return 2'd0;
    if (RegWriteM && RdM == rs) return 2'd2;
    if (RegWriteW && RdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit lwRef();
    return LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit mduRef();
    bit dep;
    dep = MduOpD || (mRd != 0 && (Rs1D == mRd || Rs2D == mRd || (RegWriteD && RdD == mRd)));
    return mBusy && mRem != 1 && dep;
  endfunction

  function automatic longint sat(input longint v);
`ifdef HAZARD_PERF_EN
    return (v < CNT_MAX) ? v + 1 : v;
`else
    return v + 1;
`endif
  endfunction

  task automatic modelReset();
    mBusy = 0; mRem = 0; mRd = '0; mLw = 0; mMdu = 0; mFl = 0;
  endtask

  task automatic modelUpdate();
    bit lw, md;
    lw = lwRef();
    md = mduRef();
    if (lw) mLw = sat(mLw);
    if (md) mMdu = sat(mMdu);
    if (PCSrcE) mFl = sat(mFl);
    if (!mBusy) begin
      if (MduStartE) begin mBusy = 1; mRem = MDU_LAT; mRd = RdE; end
    end else begin
      mRem--;
      if (mRem == 0) mBusy = 0;
    end
  endtask

  task automatic modelCheck(input string tag);
    bit st;
    st = lwRef() || mduRef();
    chk({tag, ".fwdA"}, 64'(ForwardAE), 64'(fwdRef(Rs1E)));
    chk({tag, ".fwdB"}, 64'(ForwardBE), 64'(fwdRef(Rs2E)));
    chk({tag, ".stallF"}, 64'(StallF), 64'(st));
    chk({tag, ".stallD"}, 64'(StallD), 64'(st));
    chk({tag, ".flushD"}, 64'(FlushD), 64'(PCSrcE));
    chk({tag, ".flushE"}, 64'(FlushE), 64'(st || PCSrcE));
    chk({tag, ".busy"}, 64'(MduBusy), 64'(mBusy));
    chk({tag, ".done"}, 64'(MduDone), 64'(mBusy && mRem == 1));
    chk({tag, ".mduRd"}, 64'(MduRd), 64'(mRd));
`ifdef HAZARD_PERF_EN
    chk({tag, ".lwCnt"}, 64'(LwStallCnt), 64'(mLw));
    chk({tag, ".mduCnt"}, 64'(MduStallCnt), 64'(mMdu));
    chk({tag, ".flCnt"}, 64'(FlushCnt), 64'(mFl));
`endif
  endtask

  task automatic clearIn();
    Rs1D = '0; Rs2D = '0; RdD = '0; MduOpD = 0; RegWriteD = 0;
    Rs1E = '0; Rs2E = '0; RdE = '0; LoadE = 0; MduStartE = 0; PCSrcE = 0;
    RdM = '0; RegWriteM = 0; RdW = '0; RegWriteW = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  typedef struct {
    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic             loadE, pcSrcE;
    logic [REG_W-1:0] rdM;
    logic             wM;
    logic [REG_W-1:0] rdW;
    logic             wW;
    logic [1:0]       expA, expB;
    logic             expStall, expFD, expFE;
  } vec_t;

  function automatic vec_t mkVec(input int a, b, c, d, e, f, g, h, i, j, k,
                                 input int ea, eb, es, efd, efe);
    vec_t v;
    v.rs1D = REG_W'(a); v.rs2D = REG_W'(b); v.rs1E = REG_W'(c); v.rs2E = REG_W'(d);
    v.rdE = REG_W'(e); v.loadE = 1'(f); v.pcSrcE = 1'(g); v.rdM = REG_W'(h);
    v.wM = 1'(i); v.rdW = REG_W'(j); v.wW = 1'(k);
    v.expA = 2'(ea); v.expB = 2'(eb); v.expStall = 1'(es); v.expFD = 1'(efd); v.expFE = 1'(efe);
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    // rs1D rs2D rs1E rs2E rdE ld pc rdM wM rdW wW | A B stall fD fE
    vecs[0]  = mkVec(0, 0, 5, 6, 0, 0, 0, 5, 1, 5, 1, 2, 0, 0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 6, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mkVec(0, 0, 5, 6, 0, 0, 0, 5, 0, 5, 1, 1, 0, 0, 0, 0);
    vecs[3]  = mkVec(0, 0, 3, 7, 0, 0, 0, 3, 1, 7, 1, 2, 1, 0, 0, 0);
    vecs[4]  = mkVec(0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[5]  = mkVec(0, 7, 0, 7, 0, 0, 0, 7, 1, 0, 0, 0, 2, 0, 0, 0);
    vecs[6]  = mkVec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mkVec(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[9]  = mkVec(5, 6, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mkVec(0, 0, 4, 4, 0, 0, 0, 4, 1, 4, 1, 2, 2, 0, 0, 0);
    vecs[11] = mkVec(2, 0, 2, 0, 2, 1, 0, 0, 0, 2, 1, 1, 0, 1, 0, 1);

    rst_n = 1'b0;
    clearIn();
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    modelCheck("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, MDU idle.
    for (int i = 0; i < 12; i++) begin
      clearIn();
      Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
      RdE = vecs[i].rdE; LoadE = vecs[i].loadE; PCSrcE = vecs[i].pcSrcE;
      RdM = vecs[i].rdM; RegWriteM = vecs[i].wM; RdW = vecs[i].rdW; RegWriteW = vecs[i].wW;
      settle();
      chk($sformatf("vec%0d.fwdA", i), 64'(ForwardAE), 64'(vecs[i].expA));
      chk($sformatf("vec%0d.fwdB", i), 64'(ForwardBE), 64'(vecs[i].expB));
      chk($sformatf("vec%0d.stall", i), 64'(StallD), 64'(vecs[i].expStall));
      chk($sformatf("vec%0d.flushD", i), 64'(FlushD), 64'(vecs[i].expFD));
      chk($sformatf("vec%0d.flushE", i), 64'(FlushE), 64'(vecs[i].expFE));
      modelCheck($sformatf("vec%0d", i));
      tick();
    end

    // MDU op to x9 with a dependent instruction waiting in D.
    clearIn(); MduStartE = 1; RdE = 5'd9; settle(); modelCheck("mdu1.acc"); tick();
    for (int c = 1; c <= 5; c++) begin
      clearIn(); Rs1D = 5'd9; settle();
      chk($sformatf("mdu1.c%0d.busy", c), 64'(MduBusy), 64'(c <= 4));
      chk($sformatf("mdu1.c%0d.done", c), 64'(MduDone), 64'(c == 4));
      chk($sformatf("mdu1.c%0d.stall", c), 64'(StallD), 64'(c < 4));
      chk($sformatf("mdu1.c%0d.rd", c), 64'(MduRd), 64'd9);
      modelCheck($sformatf("mdu1.c%0d", c));
      tick();
    end

    // Structural MDU stall; a taken branch mid-operation does not abort it.
    clearIn(); MduStartE = 1; RdE = 5'd2; settle(); modelCheck("mdu2.acc"); tick();
    for (int c = 1; c <= 5; c++) begin
      clearIn(); MduOpD = 1; Rs1D = 5'd11; Rs2D = 5'd12; RdD = 5'd13; RegWriteD = 1;
      PCSrcE = (c == 2);
      settle();
      chk($sformatf("mdu2.c%0d.stallF", c), 64'(StallF), 64'(c < 4));
      chk($sformatf("mdu2.c%0d.flushD", c), 64'(FlushD), 64'(c == 2));
      chk($sformatf("mdu2.c%0d.flushE", c), 64'(FlushE), 64'(c < 4));
      chk($sformatf("mdu2.c%0d.busy", c), 64'(MduBusy), 64'(c <= 4));
      chk($sformatf("mdu2.c%0d.done", c), 64'(MduDone), 64'(c == 4));
      modelCheck($sformatf("mdu2.c%0d", c));
      tick();
    end

    // Reset during BUSY cycle 2 aborts with no done pulse.
    clearIn(); MduStartE = 1; RdE = 5'd9; settle(); tick();
    clearIn(); settle(); modelCheck("rst.c1"); tick();
    clearIn(); settle();
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("rst.busy", 64'(MduBusy), 64'd0);
    chk("rst.done", 64'(MduDone), 64'd0);
    chk("rst.rd", 64'(MduRd), 64'd0);
    modelCheck("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      clearIn(); settle();
      chk($sformatf("rst.post%0d.done", c), 64'(MduDone), 64'd0);
      modelCheck($sformatf("rst.post%0d", c));
      tick();
    end

    // One load-use cycle after reset.
    clearIn(); LoadE = 1; RdE = 5'd7; Rs1D = 5'd7; settle(); modelCheck("perf.lw"); tick();
    clearIn(); settle();
`ifdef HAZARD_PERF_EN
    chk("perf.lwCnt1", 64'(LwStallCnt), 64'd1);
    chk("perf.flCnt0", 64'(FlushCnt), 64'd0);
`endif
    modelCheck("perf.after");
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      Rs1D = REG_W'($urandom_range(0, 7)); Rs2D = REG_W'($urandom_range(0, 7));
      RdD = REG_W'($urandom_range(0, 7));  MduOpD = ($urandom_range(0, 3) == 0);
      RegWriteD = 1'($urandom);
      Rs1E = REG_W'($urandom_range(0, 7)); Rs2E = REG_W'($urandom_range(0, 7));
      RdE = REG_W'($urandom_range(0, 7));  LoadE = ($urandom_range(0, 2) == 0);
      MduStartE = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      RdM = REG_W'($urandom_range(0, 7));  RegWriteM = 1'($urandom);
      RdW = REG_W'($urandom_range(0, 7));  RegWriteW = 1'($urandom);
      settle();
      modelCheck($sformatf("rnd%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
